// File: rtl/phy_pkg.sv
// Shared definitions for the two-lane transmit serializer: byte and
// counter widths, the default comma byte, and the link FSM encoding.
package phy_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;

  // Comma byte the receiver locks onto; also fills idle slots.
  localparam logic [BYTE_W-1:0] COMMA_DEFAULT = 8'hBC;

  // Link state: INIT sends the comma preamble, ACTIVE carries data.
  typedef enum logic {
    ST_INIT   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Byte that fills a slot: lane data only once the link is up and the
  // upstream byte is valid, otherwise a comma.
  function automatic logic [BYTE_W-1:0] slot_byte(
    input logic              link_up,
    input logic              valid,
    input logic [BYTE_W-1:0] data,
    input logic [BYTE_W-1:0] comma
  );
    return (link_up && valid) ? data : comma;
  endfunction

endpackage : phy_pkg

// File: rtl/phy_tx_lane.sv
// One serializer lane: loads a byte at the slot boundary and shifts it
// out MSB-first through a registered serial output, one bit per clock.
module phy_tx_lane
  import phy_pkg::*;
(
  input  logic              clk_8f,
  input  logic              reset,
  input  logic              clr,
  input  logic              load_slot,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              ser_out
);

  logic [BYTE_W-1:0] shreg;

  // Shift register and output bit: the MSB goes straight to ser_out at the
  // load edge, so the remaining seven bits are parked left-aligned in shreg
  // and slots run back-to-back with no gap bit.
  always_ff @(posedge clk_8f) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset || clr) begin
      shreg   <= '0;
      ser_out <= 1'b0;
    end else if (load_slot) begin
      ser_out <= byte_in[BYTE_W-1];
      shreg   <= {byte_in[BYTE_W-2:0], 1'b0};
    end else begin
      ser_out <= shreg[BYTE_W-1];
      shreg   <= {shreg[BYTE_W-2:0], 1'b0};
    end
  end

endmodule : phy_tx_lane

// File: rtl/phy_tx_serial.sv
// Two-lane transmit serializer. Holds the bit counter that frames byte
// slots, the INIT/ACTIVE link FSM with its comma preamble counter, the
// per-lane data/comma selection and the upstream acknowledge logic.
module phy_tx_serial
  import phy_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA   = COMMA_DEFAULT,
  parameter int unsigned       INIT_BC = 4
) (
  input  logic              clk_8f,
  input  logic              reset,
  input  logic              enable,
  input  logic [BYTE_W-1:0] data_in_0,
  input  logic              valid_in_0,
  input  logic [BYTE_W-1:0] data_in_1,
  input  logic              valid_in_1,
  output logic              load,
  output logic              data_ack_0,
  output logic              data_ack_1,
  output logic              active,
  output logic              out_0,
  output logic              out_1
);

  // Preamble counter only has to reach INIT_BC-1; keep it at least 1 bit.
  localparam int unsigned BC_W = (INIT_BC > 1) ? $clog2(INIT_BC) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(INIT_BC - 1);

  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BC_W-1:0]      bc_cnt;
  state_e               state;
  logic                 boundary;
  logic [BYTE_W-1:0]    nb_0;
  logic [BYTE_W-1:0]    nb_1;

  // The edge seen with bit_cnt==0 is the slot boundary; a disabled link
  // has no boundaries, so load also drops while enable is low.
  assign boundary   = enable && (bit_cnt == '0);
  assign load       = boundary;
  assign active     = (state == ST_ACTIVE);
  assign data_ack_0 = load && active && valid_in_0;
  assign data_ack_1 = load && active && valid_in_1;

  // Bit position within the current slot; wraps 7->0 so slots abut.
  always_ff @(posedge clk_8f) begin
    if (reset || !enable) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Link FSM: INIT_BC comma slots after reset/enable, then ACTIVE for good.
  always_ff @(posedge clk_8f) begin
    if (reset || !enable) begin
      state  <= ST_INIT;
      bc_cnt <= '0;
    end else if (boundary) begin
      unique case (state)
        ST_INIT: begin
          if (bc_cnt == BC_LAST) begin
            state  <= ST_ACTIVE;
            bc_cnt <= '0;
          end else begin
            bc_cnt <= bc_cnt + 1'b1;
          end
        end
        ST_ACTIVE: begin
          state <= ST_ACTIVE;
        end
        default: begin
          state  <= ST_INIT;
          bc_cnt <= '0;
        end
      endcase
    end
  end

  // Slot byte per lane: data when the link is up and the lane is valid,
  // comma otherwise. Lanes are selected independently.
  always_comb begin
    // NOTE: every combinational output gets a value before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    nb_0 = COMMA;
    nb_1 = COMMA;
    nb_0 = slot_byte(active, valid_in_0, data_in_0, COMMA);
    nb_1 = slot_byte(active, valid_in_1, data_in_1, COMMA);
  end

  phy_tx_lane u_lane_0 (
    .clk_8f    (clk_8f),
    .reset     (reset),
    .clr       (!enable),
    .load_slot (boundary),
    .byte_in   (nb_0),
    .ser_out   (out_0)
  );

  phy_tx_lane u_lane_1 (
    .clk_8f    (clk_8f),
    .reset     (reset),
    .clr       (!enable),
    .load_slot (boundary),
    .byte_in   (nb_1),
    .ser_out   (out_1)
  );

endmodule : phy_tx_serial

// File: tb/tb_phy_tx_serial.sv
// Directed bench for phy_tx_serial: comma preamble, data slots, idle
// lanes, mid-byte reset, enable drop and a sequence of byte pairs with
// comma gaps, each recovered by shifting the serial lanes back into bytes.
module tb_phy_tx_serial;

  logic       clk_8f = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] data_in_0;
  logic       valid_in_0;
  logic [7:0] data_in_1;
  logic       valid_in_1;
  logic       load;
  logic       data_ack_0;
  logic       data_ack_1;
  logic       active;
  logic       out_0;
  logic       out_1;

  int checks   = 0;
  int failures = 0;

  localparam logic [7:0] BC = 8'hBC;

  phy_tx_serial dut (
    .clk_8f     (clk_8f),
    .reset      (reset),
    .enable     (enable),
    .data_in_0  (data_in_0),
    .valid_in_0 (valid_in_0),
    .data_in_1  (data_in_1),
    .valid_in_1 (valid_in_1),
    .load       (load),
    .data_ack_0 (data_ack_0),
    .data_ack_1 (data_ack_1),
    .active     (active),
    .out_0      (out_0),
    .out_1      (out_1)
  );

  always #5 clk_8f = ~clk_8f;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk_8f);
    #1;
  endtask

  // Run one full slot starting at a boundary and rebuild both lane bytes.
  task automatic collect(input string tag, input logic [7:0] exp0, input logic [7:0] exp1);
    logic [7:0] b0;
    logic [7:0] b1;
    b0 = '0;
    b1 = '0;
    for (int k = 0; k < 8; k++) begin
      step();
      b0 = {b0[6:0], out_0};
      b1 = {b1[6:0], out_1};
      if (k < 7) check({tag, "_load_mid"}, {7'd0, load}, 8'd0);
    end
    check({tag, "_lane0"}, b0, exp0);
    check({tag, "_lane1"}, b1, exp1);
    check({tag, "_load_bnd"}, {7'd0, load}, 8'd1);
  endtask

  logic [7:0] pair0 [4];
  logic [7:0] pair1 [4];

  initial begin
    pair0 = '{8'h99, 8'h88, 8'h77, 8'h66};
    pair1 = '{8'h11, 8'h22, 8'h33, 8'h44};

    // 1. Reset for 8 cycles, valid data offered but must be ignored in INIT.
    reset = 1'b1; enable = 1'b1;
    data_in_0 = 8'hFF; valid_in_0 = 1'b1;
    data_in_1 = 8'hFF; valid_in_1 = 1'b1;
    repeat (8) step();
    check("rst_out0",   {7'd0, out_0},      8'd0);
    check("rst_out1",   {7'd0, out_1},      8'd0);
    check("rst_active", {7'd0, active},     8'd0);
    check("rst_load",   {7'd0, load},       8'd1);
    check("rst_ack0",   {7'd0, data_ack_0}, 8'd0);
    check("rst_ack1",   {7'd0, data_ack_1}, 8'd0);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("init_ack0",   {7'd0, data_ack_0}, 8'd0);
      check("init_ack1",   {7'd0, data_ack_1}, 8'd0);
      check("init_active", {7'd0, active},     8'd0);
      collect("init", BC, BC);
    end
    check("init_done_active", {7'd0, active}, 8'd1);

    // 2. Two data slots on both lanes.
    data_in_0 = 8'hFF; valid_in_0 = 1'b1;
    data_in_1 = 8'hEE; valid_in_1 = 1'b1;
    #1;
    check("d1_ack0", {7'd0, data_ack_0}, 8'd1);
    check("d1_ack1", {7'd0, data_ack_1}, 8'd1);
    collect("d1", 8'hFF, 8'hEE);
    data_in_0 = 8'hDD; data_in_1 = 8'hDD;
    #1;
    check("d2_ack0", {7'd0, data_ack_0}, 8'd1);
    check("d2_ack1", {7'd0, data_ack_1}, 8'd1);
    collect("d2", 8'hDD, 8'hDD);

    // 3. Lane 0 idle, lane 1 carries data.
    valid_in_0 = 1'b0;
    data_in_1  = 8'h11; valid_in_1 = 1'b1;
    #1;
    check("idle_ack0", {7'd0, data_ack_0}, 8'd0);
    check("idle_ack1", {7'd0, data_ack_1}, 8'd1);
    collect("idle", BC, 8'h11);

    // 4. Reset in the middle of a 0x99 slot.
    data_in_0 = 8'h99; valid_in_0 = 1'b1;
    data_in_1 = 8'h99; valid_in_1 = 1'b1;
    #1;
    step();
    check("mr_msb0", {7'd0, out_0}, 8'd1);
    repeat (3) step();
    reset = 1'b1;
    step();
    check("mr_out0",   {7'd0, out_0},  8'd0);
    check("mr_out1",   {7'd0, out_1},  8'd0);
    check("mr_active", {7'd0, active}, 8'd0);
    step();
    reset = 1'b0;
    #1;
    check("mr_load", {7'd0, load}, 8'd1);
    for (int i = 0; i < 4; i++) begin
      check("mr_init_ack0", {7'd0, data_ack_0}, 8'd0);
      collect("mr_init", BC, BC);
    end
    check("mr_data_ack0", {7'd0, data_ack_0}, 8'd1);
    check("mr_data_ack1", {7'd0, data_ack_1}, 8'd1);
    collect("mr_data", 8'h99, 8'h99);

    // 5. Drop enable mid-slot for 5 cycles.
    valid_in_0 = 1'b0; valid_in_1 = 1'b0;
    repeat (3) step();
    enable = 1'b0;
    data_in_0 = 8'h55; valid_in_0 = 1'b1;
    #1;
    check("en_load_low", {7'd0, load}, 8'd0);
    step();
    check("en_out0",   {7'd0, out_0},      8'd0);
    check("en_out1",   {7'd0, out_1},      8'd0);
    check("en_active", {7'd0, active},     8'd0);
    check("en_ack0",   {7'd0, data_ack_0}, 8'd0);
    repeat (4) step();
    check("en_out0_held", {7'd0, out_0}, 8'd0);
    check("en_load_held", {7'd0, load},  8'd0);
    enable = 1'b1;
    #1;
    check("en_load_back", {7'd0, load},   8'd1);
    check("en_active_0",  {7'd0, active}, 8'd0);
    for (int i = 0; i < 4; i++) collect("en_init", BC, BC);
    check("en_data_ack0", {7'd0, data_ack_0}, 8'd1);
    check("en_data_ack1", {7'd0, data_ack_1}, 8'd0);
    collect("en_data", 8'h55, BC);

    // 6. Byte pairs separated by comma slots.
    for (int i = 0; i < 4; i++) begin
      data_in_0 = pair0[i]; valid_in_0 = 1'b1;
      data_in_1 = pair1[i]; valid_in_1 = 1'b1;
      #1;
      check("lb_ack0", {7'd0, data_ack_0}, 8'd1);
      check("lb_ack1", {7'd0, data_ack_1}, 8'd1);
      collect("lb_pair", pair0[i], pair1[i]);
      valid_in_0 = 1'b0; valid_in_1 = 1'b0;
      #1;
      check("lb_gap_ack0", {7'd0, data_ack_0}, 8'd0);
      collect("lb_gap", BC, BC);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_phy_tx_serial
